std_mult_seq: RTL and testbench
===============================

STD_MULT_SEQ -- requirements
Module: std_mult_seq

Interface
REQ-001 Parameter: width, default 32, operand width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; 0 resets immediately, 1 releases.
REQ-004 Port: go  input  1  level request; held high from start of operation until done is seen.
REQ-005 Port: left  input  width  multiplicand (unsigned), sampled only at the start edge.
REQ-006 Port: right  input  width  multiplier (unsigned), sampled only at the start edge.
REQ-007 Port: out  output  width  low half of the product, registered.
REQ-008 Port: out_hi  output  width  high half of the product, registered.
REQ-009 Port: done  output  1  one-cycle pulse; out/out_hi are valid while it is high.

Function
REQ-010 Algorithm SHALL be radix-2 shift-add: one multiplier bit per cycle, LSB first, 2*width-bit accumulator; this is the inverse of the shift-subtract divider.
REQ-011 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 IDLE & go=1 at an edge (start edge E0) -> latch left/right, clear accumulator, load iteration counter with width, enter RUN.
REQ-013 RUN, each edge: if the current multiplier LSB is 1, add the multiplicand (shifted by the iteration index) into the accumulator; shift the multiplier right; decrement the counter.
REQ-014 At the edge completing the width-th iteration (E0+width), register the final accumulator into out (low half) and out_hi (high half), set done=1, and enter DONE.
REQ-015 Latency SHALL be fixed at width cycles from E0 to the edge raising done, independent of operand values (no early termination).
REQ-016 DONE, next edge: clear done, enter IDLE unconditionally; done high exactly one cycle.
REQ-017 If go is still high in IDLE after DONE, a new operation SHALL start (back-to-back), and left/right are resampled.
REQ-018 go=0 sampled in RUN SHALL abort: enter IDLE next edge, done stays 0, out/out_hi unchanged.
REQ-019 go=0 in IDLE or DONE SHALL have no effect beyond the normal transitions.
REQ-020 Product SHALL equal left*right exactly as an unsigned 2*width-bit value; overflow is impossible.
REQ-021 out/out_hi SHALL hold the last completed result until the next completion or reset; a start does not clear them.
REQ-022 left/right changes after E0 SHALL NOT affect the result in progress.

Reset
REQ-023 reset=0 SHALL asynchronously force: state=IDLE, out=0, out_hi=0, done=0, counter=0, accumulator=0.
REQ-024 Reset asserted mid-RUN SHALL discard the operation; after release the block waits in IDLE for go.
REQ-025 Release SHALL be glitch-free: no done pulse is produced by the reset release itself.

Structure
REQ-026 The FSM state enum (IDLE/RUN/DONE) SHALL live in the shared package std_arith_pkg, which the sequential arithmetic primitives share.
REQ-027 The iteration-counter width constant (clog2(width)+1) SHALL be derived locally from the width parameter.
REQ-028 No sub-module is required; a signed wrapper std_smult_seq (magnitude in, negate on sign XOR) is a separate future block instantiating this one.
REQ-029 The design SHALL be synthesizable: no * operator in the datapath, only adders and shifts.

Verification
REQ-030 width=8, left=13, right=11, go held -> done pulses 8 cycles after E0; out=143, out_hi=0.
REQ-031 width=8, left=255, right=255 -> out=0x01, out_hi=0xFE; done high exactly one cycle.
REQ-032 width=8, left=0, right=200 and left=200, right=0 -> out=0, out_hi=0, latency still 8.
REQ-033 width=8, start 7*6, drop go 3 cycles after E0 -> no done; restart 7*6 -> out=42, previous out held meanwhile.
REQ-034 width=8, assert reset 4 cycles into RUN -> out/out_hi/done=0 immediately; after release with go high, 9*9 -> out=81.
REQ-035 width=32, go held continuously across 100 random operand pairs -> every done pulse matches a 64-bit reference product, with one idle cycle between operations.

Source files
------------

// File: rtl/std_arith_pkg.sv
// Shared definitions for the sequential arithmetic primitives (multiplier, divider, ...).
package std_arith_pkg;

  // Control states shared by the iterative shift-add / shift-subtract engines.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } arith_state_e;

endpackage

// File: rtl/std_mult_seq.sv
// Sequential unsigned multiplier: radix-2 shift-add, one multiplier bit per cycle, LSB first.
// Fixed latency of `width` cycles from the start edge to the done pulse.
module std_mult_seq #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  output logic [width-1:0] out,
  output logic [width-1:0] out_hi,
  output logic             done
);

  import std_arith_pkg::*;

  // Counter must hold the value `width` itself, hence the extra bit.
  localparam int unsigned CntW = $clog2(width) + 1;
  localparam int unsigned AccW = 2 * width;

  arith_state_e    state_q;
  logic [CntW-1:0] cnt_q;
  logic [AccW-1:0] acc_q;
  logic [AccW-1:0] acc_d;
  logic [AccW-1:0] mcand_q;   // multiplicand, pre-shifted by the iteration index
  logic [width-1:0] mplier_q; // remaining multiplier bits, current bit at [0]

  // Next accumulator value: conditionally add the shifted multiplicand.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Control FSM and datapath registers, with registered result and done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      out      <= '0;
      out_hi   <= '0;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go) begin
            mcand_q  <= {{width{1'b0}}, left};
            mplier_q <= right;
            acc_q    <= '0;
            cnt_q    <= CntW'(width);
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (!go) begin
            // Abort: results and done are left untouched.
            state_q <= StIdle;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
              out     <= acc_d[width-1:0];
              out_hi  <= acc_d[AccW-1:width];
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_std_mult_seq.sv
// Scoreboard bench for std_mult_seq: an 8-bit and a 32-bit instance.
module tb_std_mult_seq;

  typedef struct {
    logic [63:0] prod;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit instance
  logic       rst8 = 1'b0;
  logic       go8 = 1'b0;
  logic [7:0] left8 = '0, right8 = '0, out8, out_hi8;
  logic       done8;
  logic       done8_prev = 1'b0;

  // 32-bit instance
  logic        rst32 = 1'b0;
  logic        go32 = 1'b0;
  logic [31:0] left32 = '0, right32 = '0, out32, out_hi32;
  logic        done32;
  logic        done32_prev = 1'b0;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;

  int n_checks = 0;
  int n_fail = 0;

  std_mult_seq #(.width(8)) u_mult8 (
    .clk    (clk),
    .reset  (rst8),
    .go     (go8),
    .left   (left8),
    .right  (right8),
    .out    (out8),
    .out_hi (out_hi8),
    .done   (done8)
  );

  std_mult_seq #(.width(32)) u_mult32 (
    .clk    (clk),
    .reset  (rst32),
    .go     (go32),
    .left   (left32),
    .right  (right32),
    .out    (out32),
    .out_hi (out_hi32),
    .done   (done32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
  endtask

  // Monitor: 8-bit instance
  always @(negedge clk) begin
    if (done8) begin
      check("done8_single_cycle", 64'(done8_prev), 64'd0);
      if (q8.size() == 0) begin
        fail("done8_unexpected");
      end else begin
        e8 = q8.pop_front();
        check("prod8", {48'd0, out_hi8, out8}, e8.prod);
        check("latency8", 64'(cyc), 64'(e8.due));
      end
    end
    done8_prev <= done8;
  end

  // Monitor: 32-bit instance
  always @(negedge clk) begin
    if (done32) begin
      check("done32_single_cycle", 64'(done32_prev), 64'd0);
      if (q32.size() == 0) begin
        fail("done32_unexpected");
      end else begin
        e32 = q32.pop_front();
        check("prod32", {out_hi32, out32}, e32.prod);
        check("latency32", 64'(cyc), 64'(e32.due));
      end
    end
    done32_prev <= done32;
  end

  task automatic wait_done8();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail("timeout8");
  endtask

  task automatic wait_done32();
    bit seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done32) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail("timeout32");
  endtask

  // One 8-bit operation; operands are scrambled right after the start edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    @(negedge clk);
    left8  = a;
    right8 = b;
    go8    = 1'b1;
    q8.push_back('{prod: 64'(p), due: cyc + 9});
    @(posedge clk);
    #1;
    left8  = 8'h5A;
    right8 = 8'hC3;
    wait_done8();
    go8 = 1'b0;
  endtask

  logic [31:0] va[7];
  logic [31:0] vb[7];
  logic [63:0] vp[7];

  task automatic pick32(input int i, output logic [31:0] a, output logic [31:0] b,
                        output logic [63:0] p);
    if (i < 7) begin
      a = va[i];
      b = vb[i];
      p = vp[i];
    end else begin
      a = $urandom;
      b = $urandom;
      p = {32'd0, a} * {32'd0, b};
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [63:0] p;

    va[0] = 32'd3;          vb[0] = 32'd5;          vp[0] = 64'h0000_0000_0000_000F;
    va[1] = 32'hFFFF_FFFF;  vb[1] = 32'hFFFF_FFFF;  vp[1] = 64'hFFFF_FFFE_0000_0001;
    va[2] = 32'h0001_0000;  vb[2] = 32'h0001_0000;  vp[2] = 64'h0000_0001_0000_0000;
    va[3] = 32'h1234_5678;  vb[3] = 32'h0000_0010;  vp[3] = 64'h0000_0001_2345_6780;
    va[4] = 32'h8000_0000;  vb[4] = 32'd2;          vp[4] = 64'h0000_0001_0000_0000;
    va[5] = 32'd0;          vb[5] = 32'hDEAD_BEEF;  vp[5] = 64'h0;
    va[6] = 32'd1;          vb[6] = 32'hDEAD_BEEF;  vp[6] = 64'h0000_0000_DEAD_BEEF;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out8", 64'(out8), 64'd0);
    check("rst_out_hi8", 64'(out_hi8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_out32", 64'(out32), 64'd0);
    check("rst_out_hi32", 64'(out_hi32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    rst8  = 1'b1;
    rst32 = 1'b1;
    repeat (2) @(negedge clk);

    // Zero operands, fixed latency
    op8(8'd0, 8'd200, 16'h0000);
    op8(8'd200, 8'd0, 16'h0000);
    op8(8'd13, 8'd11, 16'h008F);
    op8(8'd255, 8'd255, 16'hFE01);

    // Abort 7*6 by dropping go three cycles after the start edge
    @(negedge clk);
    left8  = 8'd7;
    right8 = 8'd6;
    go8    = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("held_out8_run", 64'(out8), 64'h01);
    check("held_out_hi8_run", 64'(out_hi8), 64'hFE);
    go8 = 1'b0;
    repeat (12) @(negedge clk);
    check("held_out8_abort", 64'(out8), 64'h01);
    check("held_out_hi8_abort", 64'(out_hi8), 64'hFE);
    op8(8'd7, 8'd6, 16'h002A);

    // Reset four cycles into a run
    @(negedge clk);
    left8  = 8'd5;
    right8 = 8'd5;
    go8    = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    rst8 = 1'b0;
    #1;
    check("midrst_out8", 64'(out8), 64'd0);
    check("midrst_out_hi8", 64'(out_hi8), 64'd0);
    check("midrst_done8", 64'(done8), 64'd0);
    @(negedge clk);
    left8  = 8'd9;
    right8 = 8'd9;
    @(negedge clk);
    rst8 = 1'b1;
    q8.push_back('{prod: 64'h0051, due: cyc + 9});
    @(posedge clk);
    #1;
    left8  = 8'hA5;
    right8 = 8'h3C;
    wait_done8();
    go8 = 1'b0;

    // 32-bit back-to-back with go held throughout
    @(negedge clk);
    pick32(0, a, b, p);
    left32  = a;
    right32 = b;
    go32    = 1'b1;
    q32.push_back('{prod: p, due: cyc + 33});
    for (int i = 1; i < 100; i++) begin
      wait_done32();
      pick32(i, a, b, p);
      left32  = a;
      right32 = b;
      q32.push_back('{prod: p, due: cyc + 34});
    end
    wait_done32();
    go32 = 1'b0;

    repeat (5) @(negedge clk);
    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q32_drained", 64'(q32.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
